// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers: pixel type, signed max and ReLU.
// Used by the pooling stage and reused by the downstream FC stage.
package cnn_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef logic signed [DATA_W_DEFAULT-1:0] pixel_t;

    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pixel_t relu(input pixel_t x);
        return (x < 0) ? '0 : x;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row line buffer: DEPTH x DATA_W, one sync write port, one comb read port.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr -> rd_data (read).
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic signed [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // No reset: every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU + 2x2/stride-2 max-pool over a raster-ordered feature map.
// Ports: clk, rst (async active-low), in_valid/in_data -> out_valid/out_data/out_last.
module relu_maxpool2x2
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    pixel_t        hold_q, hold_d;
    logic          out_valid_q, out_valid_d;
    pixel_t        out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    pixel_t        r;
    pixel_t        hmax;
    pixel_t        lb_rd;
    logic          lb_we;
    logic [AW-1:0] lb_addr;
    logic          col_end;
    logic          row_end;

    // Pair index within the row; the same slot is written on even rows
    // and read back on the following odd row.
    assign lb_addr = AW'(col_q >> 1);
    assign col_end = (col_q == COL_LAST);
    assign row_end = (row_q == ROW_LAST);
    assign r       = relu(in_data);
    assign hmax    = smax(hold_q, r);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        lb_we       = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_last_d  = 1'b0;
        if (in_valid) begin
            col_d = col_end ? '0 : col_q + 1'b1;
            if (col_end) begin
                row_d = row_end ? '0 : row_q + 1'b1;
            end
            if (!col_q[0]) begin
                hold_d = r;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = smax(lb_rd, hmax);
                out_last_d  = row_end && col_end;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    pool_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_lb (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (hmax),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Self-checking bench for relu_maxpool2x2: frame model + expected-output queue.
// Table of frame cases, plus reset-mid-frame and back-to-back frame sequences.
module tb_relu_maxpool2x2;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int NOUT   = (IMG_W / 2) * (IMG_H / 2);

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;

    relu_maxpool2x2 #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    typedef struct {
        int data;
        bit last;
        int cyc;
    } exp_t;

    typedef struct {
        int pat;
        int gap;
        int first_exp;
        int mid_idx;
        int mid_exp;
        int last_exp;
    } vec_t;

    exp_t exp_q[$];
    int   obs[$];
    int   fr[IMG_H][IMG_W];
    int   mr, mc;
    int   cyc_cnt;
    int   n_vec;
    int   n_fail;
    int   n_last;
    bit   mon_en;
    bit   prev_rst;
    int   prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got data=%0d last=%0b, none expected (cyc %0d)",
                             out_data, out_last, cyc_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(out_data) != e.data || out_last != e.last || cyc_cnt != e.cyc) begin
                        n_fail++;
                        $display("FAIL out_pixel: got data=%0d last=%0b cyc=%0d, want data=%0d last=%0b cyc=%0d",
                                 out_data, out_last, cyc_cnt, e.data, e.last, e.cyc);
                    end
                end
                obs.push_back(int'(out_data));
                if (out_last) n_last++;
            end else if (rst && prev_rst) begin
                n_vec++;
                if (out_last || int'(out_data) != prev_data) begin
                    n_fail++;
                    $display("FAIL idle_hold: got data=%0d last=%0b, want data=%0d last=0",
                             out_data, out_last, prev_data);
                end
            end
        end
        prev_data = int'(out_data);
        prev_rst  = rst;
    end

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0: return 16;
            1: return r * 8 + c;
            default: return (r == 3 && c == 4) ? 100 : -5;
        endcase
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic send(input int v);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        fr[mr][mc] = (v < 0) ? 0 : v;
        if (mr % 2 == 1 && mc % 2 == 1) begin
            exp_t e;
            e.data = imax(imax(fr[mr-1][mc-1], fr[mr-1][mc]),
                          imax(fr[mr][mc-1], fr[mr][mc]));
            e.last = (mr == IMG_H - 1) && (mc == IMG_W - 1);
            e.cyc  = cyc_cnt + 1;
            exp_q.push_back(e);
        end
        if (mc == IMG_W - 1) begin
            mc = 0;
            mr = (mr == IMG_H - 1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
        end
    endtask

    task automatic run_frame(input int pat, input int gap);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (gap != 0) begin
                    if (c % 2 == 1) idle(1);
                    if (($urandom & 3) == 0) idle($urandom_range(1, 3));
                end
                send(pix(pat, r, c));
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        idle(1);
        while (exp_q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending outputs, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{0, 0, 16, 0, 16, 16};
        tbl[1] = '{1, 0, 9, 4, 25, 63};
        tbl[2] = '{2, 0, 0, 6, 100, 0};
        tbl[3] = '{1, 1, 9, 4, 25, 63};

        n_vec = 0; n_fail = 0; n_last = 0;
        cyc_cnt = 0; mon_en = 1'b0; prev_rst = 1'b0; prev_data = 0;
        mr = 0; mc = 0;
        in_valid = 1'b0;
        in_data  = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_last", int'(out_last), 0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int t = 0; t < 4; t++) begin
            int lb;
            obs.delete();
            lb = n_last;
            run_frame(tbl[t].pat, tbl[t].gap);
            drain();
            check($sformatf("count_%0d", t), obs.size(), NOUT);
            check($sformatf("last_pulses_%0d", t), n_last - lb, 1);
            if (obs.size() == NOUT) begin
                check($sformatf("first_%0d", t), obs[0], tbl[t].first_exp);
                check($sformatf("mid_%0d", t), obs[tbl[t].mid_idx], tbl[t].mid_exp);
                check($sformatf("final_%0d", t), obs[NOUT-1], tbl[t].last_exp);
            end
            idle(2);
        end

        // Reset mid-frame: partial frame discarded, next pixel is (0,0).
        obs.delete();
        for (int i = 0; i < 20; i++) send(pix(1, i / IMG_W, i % IMG_W));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i * 7 + 1);
            @(negedge clk);
            check("in_reset_valid", int'(out_valid), 0);
            check("in_reset_data", int'(out_data), 0);
            check("in_reset_last", int'(out_last), 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        mr = 0; mc = 0;
        obs.delete();
        run_frame(1, 0);
        drain();
        check("rst_count", obs.size(), NOUT);
        if (obs.size() == NOUT) begin
            check("rst_first", obs[0], 9);
            check("rst_final", obs[NOUT-1], 63);
        end
        idle(2);

        // Back-to-back frames with no idle cycle between them.
        begin
            int lb;
            obs.delete();
            lb = n_last;
            run_frame(1, 0);
            run_frame(1, 0);
            drain();
            check("b2b_count", obs.size(), 2 * NOUT);
            check("b2b_last_pulses", n_last - lb, 2);
            if (obs.size() == 2 * NOUT) begin
                check("b2b_f1_final", obs[NOUT-1], 63);
                check("b2b_f2_first", obs[NOUT], 9);
                check("b2b_f2_final", obs[2*NOUT-1], 63);
            end
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
